serial_subtractor: RTL and testbench

//  Bit-serial WIDTH-bit subtractor computing a - b, LSB first, one bit per clock.

---
 rtl/serial_subtractor_pkg.sv | 16 +
 rtl/full_subtractor_cell.sv | 36 +++
 rtl/halfsubtractor.sv | 15 +
 rtl/serial_subtractor.sv | 118 +++++++++++
 tb/tb_serial_subtractor.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t : FSM state encoding, also used by the bench when peeking at
//             the controller state.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 8;
    localparam int WIDTH_MIN     = 2;
    localparam int WIDTH_MAX     = 32;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor built from two half subtractors, purely combinational.
//   x, y : operand bits (computes x - y - bin)
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d_hs1;
    logic b_hs1;
    logic b_hs2;

    halfsubtractor u_hs1 (
        .x (x),
        .y (y),
        .d (d_hs1),
        .b (b_hs1)
    );

    // Second stage subtracts the incoming borrow from the first difference;
    // its borrow can only fire when x==y, so the two borrows never overlap.
    halfsubtractor u_hs2 (
        .x (d_hs1),
        .y (bin),
        .d (d),
        .b (b_hs2)
    );

    assign bout = b_hs1 | b_hs2;

endmodule

// File: rtl/halfsubtractor.sv
// One-bit half subtractor, purely combinational.
//   x, y : operand bits (computes x - y)
//   d    : difference bit
//   b    : borrow out (set when x=0, y=1)
module halfsubtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic b
);

    assign d = x ^ y;
    assign b = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, processed LSB first, one bit
// per clock through a single full-subtractor cell.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : request, accepted only in IDLE (operands sampled then)
//   a, b       : minuend / subtrahend
//   busy       : high in SHIFT and DONE
//   done       : one-cycle pulse when diff/borrow_out were just updated
//   diff       : (a - b) mod 2^WIDTH, held until the next done
//   borrow_out : 1 iff a < b, held until the next done
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_SHIFT | one operand bit per cycle, cnt = bit index being processed
// ST_DONE  | results valid and freshly loaded, done asserted
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sr_a;
    logic [WIDTH-1:0] sr_b;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nx;
    logic [CNT_W-1:0] cnt;
    logic             bflop;
    logic             cell_d;
    logic             cell_bout;
    logic             last_bit;

    full_subtractor_cell u_cell (
        .x    (sr_a[0]),
        .y    (sr_b[0]),
        .bin  (bflop),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign last_bit = (cnt == CNT_LAST);
    // New difference bits enter at the MSB so that after WIDTH shifts the
    // LSB-first stream lines up with bit 0.
    assign work_nx  = {cell_d, work[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_a       <= '0;
            sr_b       <= '0;
            work       <= '0;
            cnt        <= '0;
            bflop      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sr_a  <= a;
                        sr_b  <= b;
                        work  <= '0;
                        cnt   <= '0;
                        bflop <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    sr_a  <= {1'b0, sr_a[WIDTH-1:1]};
                    sr_b  <= {1'b0, sr_b[WIDTH-1:1]};
                    work  <= work_nx;
                    bflop <= cell_bout;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        diff       <= work_nx;
                        borrow_out <= cell_bout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    int checks;
    int errors;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launches one operation and observes 16 cycles after the accepting edge.
    // Sample index i corresponds to the cycle following edge k+i.
    // glitch_at >= 0 pulses start (a=11, b=22) for one cycle at that index.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input int glitch_at,
                          output logic [7:0] rdiff, output logic rbor,
                          output int busy_n, output int done_n, output int done_at,
                          output bit early_change);
        logic [7:0] d0;
        logic       b0;
        a = ta; b = tbv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
        d0 = diff; b0 = borrow_out;
        rdiff = 'x; rbor = 1'bx;
        busy_n = 0; done_n = 0; done_at = -1; early_change = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = i;
                rdiff = diff; rbor = borrow_out;
            end else if (done_n == 0 && (diff !== d0 || borrow_out !== b0)) begin
                early_change = 1'b1;
            end
            if (i == glitch_at) begin
                start = 1'b1; a = 8'h11; b = 8'h22;
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b diff=%h borrow=%b, want 0 0 00 0",
                     busy, done, diff, borrow_out);
        end
        checks++;
        if (dut.state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want %0d", dut.state, ST_IDLE);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] rd; logic rb; int bn, dn, da; bit ec;

        run_op(8'h5A, 8'h3C, -1, rd, rb, bn, dn, da, ec);
        checks++;
        if (rd !== 8'h1E || rb !== 1'b0) begin
            errors++; $display("FAIL sub_5A_3C: got %h/%b want 1e/0", rd, rb);
        end
        checks++;
        if (da !== 8) begin
            errors++; $display("FAIL latency_5A_3C: done at %0d want 8", da);
        end
        checks++;
        if (dn !== 1) begin
            errors++; $display("FAIL done_count_5A_3C: got %0d want 1", dn);
        end
        checks++;
        if (ec) begin
            errors++; $display("FAIL diff_stable_5A_3C: got changed want stable");
        end

        run_op(8'h00, 8'h01, -1, rd, rb, bn, dn, da, ec);
        checks++;
        if (rd !== 8'hFF || rb !== 1'b1) begin
            errors++; $display("FAIL sub_00_01: got %h/%b want ff/1", rd, rb);
        end
        checks++;
        if (bn !== 9) begin
            errors++; $display("FAIL busy_cycles_00_01: got %0d want 9", bn);
        end

        run_op(8'hFF, 8'hFF, -1, rd, rb, bn, dn, da, ec);
        checks++;
        if (rd !== 8'h00 || rb !== 1'b0) begin
            errors++; $display("FAIL sub_FF_FF: got %h/%b want 00/0", rd, rb);
        end

        run_op(8'h80, 8'h7F, -1, rd, rb, bn, dn, da, ec);
        checks++;
        if (rd !== 8'h01 || rb !== 1'b0) begin
            errors++; $display("FAIL sub_80_7F: got %h/%b want 01/0", rd, rb);
        end

        run_op(8'hA7, 8'h00, -1, rd, rb, bn, dn, da, ec);
        checks++;
        if (rd !== 8'hA7 || rb !== 1'b0) begin
            errors++; $display("FAIL sub_A7_00: got %h/%b want a7/0", rd, rb);
        end

        // result must hold after done drops
        checks++;
        if (diff !== 8'hA7 || borrow_out !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_A7: got %h/%b busy=%b want a7/0 busy=0", diff, borrow_out, busy);
        end
    endtask

    task automatic test_ignore_start();
        logic [7:0] rd; logic rb; int bn, dn, da; bit ec;
        run_op(8'h40, 8'h05, 3, rd, rb, bn, dn, da, ec);
        checks++;
        if (rd !== 8'h3B || rb !== 1'b0) begin
            errors++; $display("FAIL ignore_start_result: got %h/%b want 3b/0", rd, rb);
        end
        checks++;
        if (dn !== 1 || da !== 8) begin
            errors++; $display("FAIL ignore_start_done: count %0d at %0d want 1 at 8", dn, da);
        end
        checks++;
        if (bn !== 9) begin
            errors++; $display("FAIL ignore_start_busy: got %0d want 9", bn);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd; logic rb; int bn, dn, da; bit ec;
        int ndone;
        a = 8'h5A; b = 8'h3C; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (dut.cnt !== 3'd4 || dut.state !== ST_SHIFT) begin
            errors++; $display("FAIL mid_cnt: cnt=%0d state=%0d want 4 %0d", dut.cnt, dut.state, ST_SHIFT);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%b done=%b diff=%h borrow=%b want 0 0 00 0",
                     busy, done, diff, borrow_out);
        end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        checks++;
        if (ndone !== 0) begin
            errors++; $display("FAIL mid_reset_no_done: got %0d active cycles want 0", ndone);
        end
        run_op(8'h10, 8'h01, -1, rd, rb, bn, dn, da, ec);
        checks++;
        if (rd !== 8'h0F || rb !== 1'b0 || dn !== 1) begin
            errors++; $display("FAIL after_reset_10_01: got %h/%b dn=%0d want 0f/0 dn=1", rd, rb, dn);
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        int at [3];
        logic [7:0] dv [3];
        ndone = 0;
        a = 8'h09; b = 8'h03; start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                if (ndone < 3) begin
                    at[ndone] = i; dv[ndone] = diff;
                end
                ndone++;
            end
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (ndone !== 3) begin
            errors++; $display("FAIL b2b_done_count: got %0d want 3", ndone);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (at[k] !== 8 + 10 * k || dv[k] !== 8'h06) begin
                    errors++;
                    $display("FAIL b2b_op%0d: done at %0d diff %h want at %0d diff 06",
                             k, at[k], dv[k], 8 + 10 * k);
                end
            end
        end
    endtask

    task automatic test_sweep();
        logic [7:0] rd; logic rb; int bn, dn, da; bit ec;
        logic [7:0] ta, tbv;
        logic [8:0] ref9;
        for (int n = 0; n < 120; n++) begin
            ta = 8'($urandom); tbv = 8'($urandom);
            if (n == 0) begin ta = 8'h00; tbv = 8'hFF; end
            if (n == 1) begin ta = 8'h7F; tbv = 8'h80; end
            ref9 = {1'b0, ta} - {1'b0, tbv};
            run_op(ta, tbv, -1, rd, rb, bn, dn, da, ec);
            checks++;
            if (rd !== ref9[7:0] || rb !== ref9[8] || dn !== 1) begin
                errors++;
                $display("FAIL sweep_%h_%h: got %h/%b dn=%0d want %h/%b dn=1",
                         ta, tbv, rd, rb, dn, ref9[7:0], ref9[8]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
